// File: rtl/eth_receive.sv
// eth_receive: GMII frame receiver: strips preamble/SFD, parses header, streams payload without FCS and checks CRC-32.
// Optional destination filter enabled by defining ETH_RX_MAC_FILTER_EN.
module eth_receive #(
  parameter logic [47:0] LOCAL_MAC   = 48'h000a3501fec0,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rx_data,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [47:0] rx_dst_mac,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_frame_type,
  output logic        rx_hdr_valid,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic [15:0] rx_payload_len,
  output logic        rx_frame_done,
  output logic        rx_frame_ok,
  output logic        rx_frame_err
);
`ifdef ETH_RX_MAC_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP} state_t;
  state_t state, state_n;
  logic [7:0] d_r;
  logic dv_r, er_r, dv_p;
  logic [31:0] crc;
  logic [15:0] bcnt, plen;
  logic [3:0][7:0] line;
  logic [2:0] fill;
  logic er_f, ovf;
  logic in_frame, take, sfd, eject, good, reject;
  logic [47:0] dst_n;
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction
  // Input stage is left unreset so dv history survives reset and a mid-frame reset cannot look like a frame start.
  always_ff @(posedge gmii_rx_clk) begin
    d_r  <= gmii_rx_data;
    dv_r <= gmii_rx_dv;
    er_r <= gmii_rx_er;
    dv_p <= dv_r;
  end
  always_ff @(posedge gmii_rx_clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !dv_r ? IDLE : (d_r == 8'h55 && !dv_p) ? PREAMBLE : DROP;
      PREAMBLE: state_n = !dv_r ? IDLE : d_r == 8'h55 ? PREAMBLE : d_r == 8'hD5 ? DST : DROP;
      DST:      state_n = !dv_r ? IDLE : bcnt == 16'd5 ? (reject ? DROP : SRC) : DST;
      SRC:      state_n = !dv_r ? IDLE : bcnt == 16'd11 ? TYPE : SRC;
      TYPE:     state_n = !dv_r ? IDLE : bcnt == 16'd13 ? PAYLOAD : TYPE;
      PAYLOAD:  state_n = !dv_r ? IDLE : PAYLOAD;
      default:  state_n = !dv_r ? IDLE : DROP;
    endcase
  end
  always_comb begin
    in_frame = state == DST || state == SRC || state == TYPE || state == PAYLOAD;
    take     = in_frame && dv_r;
    sfd      = state == PREAMBLE && dv_r && d_r == 8'hD5;
    eject    = take && state == PAYLOAD && fill == 3'd4;
    dst_n    = {rx_dst_mac[39:0], d_r};
    reject   = FILTER && dst_n != LOCAL_MAC && dst_n != '1;
    good     = !er_f && !ovf && crc == 32'hDEBB20E3 && state == PAYLOAD && fill == 3'd4;
  end
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      rx_dst_mac <= '0; rx_src_mac <= '0; rx_frame_type <= '0; rx_hdr_valid <= 1'b0;
      rx_data <= '0; rx_data_valid <= 1'b0; rx_payload_len <= '0;
      rx_frame_done <= 1'b0; rx_frame_ok <= 1'b0; rx_frame_err <= 1'b0;
      crc <= '0; bcnt <= '0; plen <= '0; line <= '0; fill <= '0; er_f <= 1'b0; ovf <= 1'b0;
    end else begin
      rx_hdr_valid  <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_frame_done <= 1'b0;
      if (sfd) begin
        crc <= '1; bcnt <= '0; plen <= '0; fill <= '0; er_f <= 1'b0; ovf <= 1'b0;
      end
      if (take) begin
        crc  <= crc_next(crc, d_r);
        bcnt <= bcnt == 16'hFFFF ? bcnt : bcnt + 16'd1;
        if (er_r) er_f <= 1'b1;
        if (state == DST) rx_dst_mac <= dst_n;
        if (state == SRC) rx_src_mac <= {rx_src_mac[39:0], d_r};
        if (state == TYPE) rx_frame_type <= {rx_frame_type[7:0], d_r};
        if (state == TYPE && bcnt == 16'd13) rx_hdr_valid <= 1'b1;
        if (state == PAYLOAD) begin
          line <= {line[2:0], d_r};
          fill <= fill == 3'd4 ? fill : fill + 3'd1;
        end
      end
      if (eject) begin
        if (plen == 16'(MAX_PAYLOAD)) ovf <= 1'b1;
        else begin
          rx_data       <= line[3];
          rx_data_valid <= 1'b1;
          plen          <= plen + 16'd1;
        end
      end
      if (in_frame && !dv_r) begin
        rx_frame_done  <= 1'b1;
        rx_frame_ok    <= good;
        rx_frame_err   <= !good;
        rx_payload_len <= plen;
      end
    end
  end
endmodule

// File: tb/tb_eth_receive.sv
// tb_eth_receive: scoreboard bench for eth_receive; stimulus pushes expectations, a monitor pops on DUT strobes.
module tb_eth_receive;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] din = '0;
  logic dv = 1'b0, er = 1'b0;
  logic [47:0] rx_dst_mac, rx_src_mac;
  logic [15:0] rx_frame_type, rx_payload_len;
  logic rx_hdr_valid, rx_data_valid, rx_frame_done, rx_frame_ok, rx_frame_err;
  logic [7:0] rx_data;
  int checks = 0, failures = 0;
  typedef struct {logic [47:0] dst; logic [47:0] src; logic [15:0] typ;} hdr_t;
  typedef struct {logic ok; logic [15:0] len;} done_t;
  logic [7:0] exp_data[$];
  hdr_t exp_hdr[$];
  done_t exp_done[$];
  logic [7:0] frm[$];
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SMAC  = 48'h000a3501fec1;
  localparam logic [47:0] LMAC  = 48'h000a3501fec0;
  localparam logic [47:0] OMAC  = 48'h001122334455;
  always #4 clk = ~clk;
  eth_receive dut (
    .gmii_rx_clk(clk), .rst(rst), .gmii_rx_data(din), .gmii_rx_dv(dv), .gmii_rx_er(er),
    .rx_dst_mac(rx_dst_mac), .rx_src_mac(rx_src_mac), .rx_frame_type(rx_frame_type),
    .rx_hdr_valid(rx_hdr_valid), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_payload_len(rx_payload_len), .rx_frame_done(rx_frame_done),
    .rx_frame_ok(rx_frame_ok), .rx_frame_err(rx_frame_err)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return c;
  endfunction
  task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                       input int n, input int base, input bit bad);
    logic [31:0] c;
    logic [7:0] b;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    c = '1;
    for (int i = 0; i < 14 + n; i++) begin
      b = i < 6 ? dst[47 - 8*i -: 8] : i < 12 ? src[47 - 8*(i-6) -: 8] : i < 14 ? typ[15 - 8*(i-12) -: 8] : 8'(base + i - 14);
      frm.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    if (bad) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
  endtask
  task automatic expect_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                              input int n, input int base, input logic ok);
    int m;
    hdr_t h;
    done_t d;
    m = n > 1500 ? 1500 : n;
    for (int i = 0; i < m; i++) exp_data.push_back(8'(base + i));
    h.dst = dst; h.src = src; h.typ = typ;
    exp_hdr.push_back(h);
    d.ok = ok; d.len = 16'(m);
    exp_done.push_back(d);
  endtask
  task automatic send(input int er_idx, input int gap);
    for (int i = 0; i < frm.size(); i++) begin
      @(negedge clk);
      din = frm[i]; dv = 1'b1; er = (i == er_idx);
    end
    @(negedge clk);
    dv = 1'b0; er = 1'b0; din = '0;
    repeat (gap - 1) @(negedge clk);
  endtask
  always @(negedge clk) if (!rst) begin
    if (rx_data_valid) begin
      if (exp_data.size() == 0) chk("extra_data", 64'(rx_data), 64'hx);
      else chk("data", 64'(rx_data), 64'(exp_data.pop_front()));
    end
    if (rx_hdr_valid) begin
      if (exp_hdr.size() == 0) chk("extra_hdr", 1, 0);
      else begin
        hdr_t h;
        h = exp_hdr.pop_front();
        chk("dst_mac", 64'(rx_dst_mac), 64'(h.dst));
        chk("src_mac", 64'(rx_src_mac), 64'(h.src));
        chk("frame_type", 64'(rx_frame_type), 64'(h.typ));
      end
    end
    if (rx_frame_done) begin
      if (exp_done.size() == 0) chk("extra_done", 1, 0);
      else begin
        done_t d;
        d = exp_done.pop_front();
        chk("frame_ok", 64'(rx_frame_ok), 64'(d.ok));
        chk("frame_err", 64'(rx_frame_err), 64'(!d.ok));
        chk("payload_len", 64'(rx_payload_len), 64'(d.len));
      end
    end
  end
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_data_valid", 64'(rx_data_valid), 0);
    chk("rst_hdr_valid", 64'(rx_hdr_valid), 0);
    chk("rst_done", 64'(rx_frame_done), 0);
    chk("rst_dst_mac", 64'(rx_dst_mac), 0);
    chk("rst_len", 64'(rx_payload_len), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    build(BCAST, SMAC, 16'h0806, 46, 0, 0);
    expect_frame(BCAST, SMAC, 16'h0806, 46, 0, 1);
    send(-1, 3);
    build(BCAST, SMAC, 16'h0806, 46, 0, 1);
    expect_frame(BCAST, SMAC, 16'h0806, 46, 0, 0);
    send(-1, 3);
    build(BCAST, SMAC, 16'h0800, 46, 8'h20, 0);
    expect_frame(BCAST, SMAC, 16'h0800, 46, 8'h20, 0);
    send(8 + 14 + 20, 3);
    foreach (frm[i]) if (i < 3) frm[i] = 8'h55;
    frm[2] = 8'h5D;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      din = i < 3 ? frm[i] : 8'hD5; dv = 1'b1;
    end
    @(negedge clk);
    dv = 1'b0;
    @(negedge clk);
    build(BCAST, SMAC, 16'h0806, 46, 8'h80, 0);
    expect_frame(BCAST, SMAC, 16'h0806, 46, 8'h80, 1);
    send(-1, 1);
    build(LMAC, SMAC, 16'h0800, 50, 8'h10, 0);
    expect_frame(LMAC, SMAC, 16'h0800, 50, 8'h10, 1);
    send(-1, 1);
    build(BCAST, SMAC, 16'h0806, 46, 8'hA0, 0);
    expect_frame(BCAST, SMAC, 16'h0806, 46, 8'hA0, 1);
    send(-1, 3);
    build(BCAST, SMAC, 16'h0806, 46, 0, 0);
    frm = frm[0:17];
    exp_done.push_back('{ok: 1'b0, len: 16'd0});
    send(-1, 3);
    build(OMAC, SMAC, 16'h0800, 46, 8'h30, 0);
`ifndef ETH_RX_MAC_FILTER_EN
    expect_frame(OMAC, SMAC, 16'h0800, 46, 8'h30, 1);
`endif
    send(-1, 3);
    build(LMAC, SMAC, 16'h0800, 46, 8'h60, 0);
    expect_frame(LMAC, SMAC, 16'h0800, 46, 8'h60, 1);
    send(-1, 3);
    build(BCAST, SMAC, 16'h0800, 1501, 0, 0);
    expect_frame(BCAST, SMAC, 16'h0800, 1501, 0, 0);
    send(-1, 3);
    repeat (10) @(negedge clk);
    chk("data_left", 64'(exp_data.size()), 0);
    chk("hdr_left", 64'(exp_hdr.size()), 0);
    chk("done_left", 64'(exp_done.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
